eq_serial_ctrl: RTL and testbench

- Bit-serial N-bit equality checker: a controller sequences a single shared 1-bit equality cell (eq = ~i0 & ~i1 | i0 & i1) across two N-bit operands, one bit per clock, LSB first.
- Stops early on the first mismatch and reports the result with a start/ready/done_tick handshake.
- Sits beside the combinational comparator family as the area-minimal sequential alternative for wide compares.

---
 rtl/eq_serial_ctrl.sv | 103 ++++++++++
 tb/tb_eq_serial_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/eq_serial_ctrl.sv
// Bit-serial N-bit equality checker.
// One shared 1-bit eq cell walks the operands LSB first and stops on the first mismatch.
module eq_serial_ctrl #(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         ready,
  output logic         done_tick,
  output logic         eq,
  output logic [W-1:0] diff_idx
);

  typedef enum logic [1:0] {
    IDLE,
    CMP,
    DONE
  } state_t;

  localparam logic [W-1:0] LAST = W'(N - 1);

  state_t       state;
  state_t       state_n;
  logic [N-1:0] a_reg;
  logic [N-1:0] b_reg;
  logic [W-1:0] cnt;
  logic         bit_eq;
  logic         last;

  function automatic logic eq_cell(
    input logic i0,
    input logic i1
  );
    return (~i0 & ~i1) | (i0 & i1);
  endfunction

  assign bit_eq = eq_cell(a_reg[0], b_reg[0]);
  assign last   = (cnt == LAST);

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (start) state_n = CMP;
      CMP:  if (!bit_eq || last) state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // ready/done_tick are registered from the next state so they are glitch-free.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      ready     <= 1'b1;
      done_tick <= 1'b0;
    end else begin
      state     <= state_n;
      ready     <= (state_n == IDLE);
      done_tick <= (state_n == DONE);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_reg    <= '0;
      b_reg    <= '0;
      cnt      <= '0;
      eq       <= 1'b0;
      diff_idx <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a_reg    <= a;
            b_reg    <= b;
            cnt      <= '0;
            eq       <= 1'b0;
            diff_idx <= '0;
          end
        end
        CMP: begin
          if (!bit_eq) begin
            eq       <= 1'b0;
            diff_idx <= cnt;
          end else if (last) begin
            eq       <= 1'b1;
            diff_idx <= '0;
          end else begin
            a_reg <= a_reg >> 1;
            b_reg <= b_reg >> 1;
            cnt   <= cnt + W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_eq_serial_ctrl.sv
// Scoreboard bench for eq_serial_ctrl at N=8 and N=5.
// Drivers push expected results; monitors pop them on done_tick.
module tb_eq_serial_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       rdy8, dt8, eq8;
  logic [2:0] idx8;

  logic       start5 = 1'b0;
  logic [4:0] a5 = '0;
  logic [4:0] b5 = '0;
  logic       rdy5, dt5, eq5;
  logic [2:0] idx5;

  eq_serial_ctrl #(.N(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .start(start8),
    .a(a8), .b(b8), .ready(rdy8), .done_tick(dt8),
    .eq(eq8), .diff_idx(idx8)
  );

  eq_serial_ctrl #(.N(5)) dut5 (
    .clk(clk), .reset_n(reset_n), .start(start5),
    .a(a5), .b(b5), .ready(rdy5), .done_tick(dt5),
    .eq(eq5), .diff_idx(idx5)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic eq;
    int   idx;
    int   t0;
    int   lat;
  } exp_t;

  exp_t q8[$];
  exp_t q5[$];
  exp_t e8, e5;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // t0 is the cycle count right after the accept edge; done in cycle L
  // is seen at the negedge where cyc == t0 + L - 1.
  always @(negedge clk) begin
    if (reset_n && dt8 !== 1'b0) begin
      chk("dt8_ready_excl", rdy8, 0);
      if (q8.size() == 0) begin
        chk("dt8_unexpected", dt8, 0);
      end else begin
        e8 = q8.pop_front();
        chk("eq8", eq8, e8.eq);
        chk("idx8", idx8, e8.idx);
        chk("lat8", cyc - e8.t0 + 1, e8.lat);
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n && dt5 !== 1'b0) begin
      chk("dt5_ready_excl", rdy5, 0);
      if (q5.size() == 0) begin
        chk("dt5_unexpected", dt5, 0);
      end else begin
        e5 = q5.pop_front();
        chk("eq5", eq5, e5.eq);
        chk("idx5", idx5, e5.idx);
        chk("lat5", cyc - e5.t0 + 1, e5.lat);
      end
    end
  end

  task automatic wait_rdy8();
    int n = 0;
    @(negedge clk);
    while (!rdy8 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!rdy8) chk("rdy8_timeout", rdy8, 1);
  endtask

  task automatic issue8(input logic [7:0] av, input logic [7:0] bv,
                        input logic e, input int idx, input int lat);
    exp_t x;
    wait_rdy8();
    start8 = 1'b1;
    a8 = av;
    b8 = bv;
    @(posedge clk);
    #1;
    x.eq = e; x.idx = idx; x.t0 = cyc; x.lat = lat;
    q8.push_back(x);
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom);
    b8 = 8'($urandom);
  endtask

  task automatic issue5(input logic [4:0] av, input logic [4:0] bv,
                        input logic e, input int idx, input int lat);
    exp_t x;
    int n = 0;
    @(negedge clk);
    while (!rdy5 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!rdy5) chk("rdy5_timeout", rdy5, 1);
    start5 = 1'b1;
    a5 = av;
    b5 = bv;
    @(posedge clk);
    #1;
    x.eq = e; x.idx = idx; x.t0 = cyc; x.lat = lat;
    q5.push_back(x);
    @(negedge clk);
    start5 = 1'b0;
    a5 = 5'($urandom);
    b5 = 5'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while ((q8.size() != 0 || q5.size() != 0) && n < 60) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("drain8", q8.size(), 0);
    chk("drain5", q5.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int t_first;
    int n;
    exp_t x;

    // reset and idle
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("idle_ready", rdy8, 1);
      chk("idle_done", dt8, 0);
      chk("idle_eq", eq8, 0);
      chk("idle_idx", idx8, 0);
      chk("idle_ready5", rdy5, 1);
    end

    // full match, then eq held until next start
    issue8(8'hA5, 8'hA5, 1'b1, 0, 9);
    repeat (8) @(negedge clk);
    chk("match_dt_c9", dt8, 1);
    @(negedge clk);
    chk("match_dt_c10", dt8, 0);
    chk("match_rdy_c10", rdy8, 1);
    chk("match_eq_c10", eq8, 1);
    repeat (4) begin
      @(negedge clk);
      chk("match_eq_hold", eq8, 1);
      chk("match_idx_hold", idx8, 0);
    end

    // early mismatch; start clears eq
    issue8(8'h08, 8'h00, 1'b0, 3, 5);
    chk("eq_clr_on_start", eq8, 0);
    chk("busy_not_ready", rdy8, 0);
    drain();
    chk("mis3_eq_hold", eq8, 0);
    chk("mis3_idx_hold", idx8, 3);

    issue8(8'h01, 8'h00, 1'b0, 0, 2);
    drain();
    issue8(8'h80, 8'h00, 1'b0, 7, 9);
    drain();
    issue8(8'h5A, 8'h4A, 1'b0, 4, 6);
    drain();

    // start held through CMP/DONE with changing operands
    wait_rdy8();
    start8 = 1'b1;
    a8 = 8'h10;
    b8 = 8'h00;
    @(posedge clk);
    #1;
    x.eq = 1'b0; x.idx = 4; x.t0 = cyc; x.lat = 6;
    q8.push_back(x);
    t_first = cyc;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!rdy8) begin
        a8 = 8'($urandom);
        b8 = 8'($urandom);
      end
    end while (!rdy8 && n < 50);
    chk("busy_rdy_seen", rdy8, 1);
    a8 = 8'h3C;
    b8 = 8'h3C;
    @(posedge clk);
    #1;
    x.eq = 1'b1; x.idx = 0; x.t0 = cyc; x.lat = 9;
    q8.push_back(x);
    chk("busy_restart_gap", cyc - t_first, 7);
    @(negedge clk);
    start8 = 1'b0;
    drain();

    // reset in cycle 4 of an FF/FF compare
    wait_rdy8();
    start8 = 1'b1;
    a8 = 8'hFF;
    b8 = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_ready", rdy8, 1);
    chk("rst_mid_done", dt8, 0);
    chk("rst_mid_eq", eq8, 0);
    chk("rst_mid_idx", idx8, 0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("rst_no_done", dt8, 0);
    end
    issue8(8'hC3, 8'hC3, 1'b1, 0, 9);
    drain();
    issue8(8'hC3, 8'hE3, 1'b0, 5, 7);
    drain();

    // odd width N=5
    issue5(5'h1B, 5'h1B, 1'b1, 0, 6);
    drain();
    chk("n5_eq_hold", eq5, 1);
    issue5(5'h10, 5'h00, 1'b0, 4, 6);
    drain();
    issue5(5'h1B, 5'h19, 1'b0, 1, 3);
    drain();

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
